// File: rtl/lfsr_prbs_checker.sv
// Receive-side PRBS checker: self-synchronises a reference LFSR to the incoming
// word stream, then flywheels and counts word mismatches while locked.
module lfsr_prbs_checker #(
    parameter int NUM_BITS      = 4,
    parameter int LOCK_COUNT    = 4,
    parameter int UNLOCK_COUNT  = 3,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst_L,
    input  logic                     i_Data_DV,
    input  logic [NUM_BITS-1:0]      i_Data,
    input  logic                     i_Clear,
    output logic                     o_Locked,
    output logic                     o_Error,
    output logic [ERR_CNT_WIDTH-1:0] o_Err_Count
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(UNLOCK_COUNT + 1);
    localparam logic [GW-1:0] LOCK_TGT   = GW'(LOCK_COUNT);
    localparam logic [BW-1:0] UNLOCK_TGT = BW'(UNLOCK_COUNT);
    localparam logic [NUM_BITS-1:0] LOCKUP_WORD = {NUM_BITS{1'b1}};

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Zero-extending to 8 bits keeps every tap index legal for any NUM_BITS.
    function automatic logic [NUM_BITS-1:0] lfsr_next(input logic [NUM_BITS-1:0] x);
        logic [7:0] w;
        logic       fb;
        w = 8'(x);
        case (NUM_BITS)
            3:       fb = ~(w[2] ^ w[1]);
            4:       fb = ~(w[3] ^ w[2]);
            5:       fb = ~(w[4] ^ w[2]);
            6:       fb = ~(w[5] ^ w[4]);
            7:       fb = ~(w[6] ^ w[5]);
            8:       fb = ~(w[7] ^ w[5] ^ w[4] ^ w[3]);
            default: fb = 1'b0;
        endcase
        return {x[NUM_BITS-2:0], fb};
    endfunction

    state_t                     state_q, state_d;
    logic [NUM_BITS-1:0]        ref_q, ref_d;
    logic [GW-1:0]              good_cnt_q, good_cnt_d, good_inc_s;
    logic [BW-1:0]              bad_cnt_q, bad_cnt_d, bad_inc_s;
    logic [ERR_CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;
    logic                       error_q, error_d;
    logic                       locked_q, locked_d;
    logic                       match_s;

    assign match_s    = (i_Data == ref_q);
    assign good_inc_s = good_cnt_q + GW'(1);
    assign bad_inc_s  = bad_cnt_q + BW'(1);

    // Next-state, reference and counter logic.
    always_comb begin
        state_d    = state_q;
        ref_d      = ref_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        err_cnt_d  = err_cnt_q;
        error_d    = 1'b0;
        if (i_Data_DV) begin
            case (state_q)
                HUNT: begin
                    if (i_Data == LOCKUP_WORD) begin
                        state_d = HUNT;
                    end else begin
                        ref_d      = lfsr_next(i_Data);
                        good_cnt_d = '0;
                        state_d    = SYNC;
                    end
                end
                SYNC: begin
                    if (i_Data == LOCKUP_WORD) begin
                        state_d = HUNT;
                    end else if (match_s) begin
                        ref_d      = lfsr_next(i_Data);
                        good_cnt_d = good_inc_s;
                        if (good_inc_s == LOCK_TGT) begin
                            state_d   = LOCKED;
                            bad_cnt_d = '0;
                        end else begin
                            state_d = SYNC;
                        end
                    end else begin
                        ref_d      = lfsr_next(i_Data);
                        good_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: once locked the reference never follows the data.
                    ref_d = lfsr_next(ref_q);
                    if (match_s) begin
                        bad_cnt_d = '0;
                    end else begin
                        error_d   = 1'b1;
                        bad_cnt_d = bad_inc_s;
                        if (err_cnt_q != {ERR_CNT_WIDTH{1'b1}}) begin
                            err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
                        end else begin
                            err_cnt_d = err_cnt_q;
                        end
                        if (bad_inc_s == UNLOCK_TGT) begin
                            state_d = HUNT;
                        end else begin
                            state_d = LOCKED;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end else begin
            state_d = state_q;
        end
        if (i_Clear) begin
            err_cnt_d = '0;
        end else begin
            err_cnt_d = err_cnt_d;
        end
        locked_d = (state_d == LOCKED);
    end

    // State and registered outputs.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q    <= HUNT;
            ref_q      <= '0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            err_cnt_q  <= '0;
            error_q    <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ref_q      <= ref_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            err_cnt_q  <= err_cnt_d;
            error_q    <= error_d;
            locked_q   <= locked_d;
        end
    end

    assign o_Locked    = locked_q;
    assign o_Error     = error_q;
    assign o_Err_Count = err_cnt_q;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Directed bench for lfsr_prbs_checker (NUM_BITS=4) with a second 2-bit-counter
// instance sharing the same stimulus to observe saturation.
module tb_lfsr_prbs_checker;

    logic       clk;
    logic       rst_n;
    logic       dv;
    logic [3:0] data;
    logic       clr;
    logic       locked, err;
    logic [15:0] cnt;
    logic       locked_s, err_s;
    logic [1:0] cnt_s;

    int checks = 0;
    int errors = 0;
    int idx    = 0;
    logic [3:0] seq [15];

    lfsr_prbs_checker #(.NUM_BITS(4), .LOCK_COUNT(4), .UNLOCK_COUNT(3), .ERR_CNT_WIDTH(16)) u_dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Data_DV(dv), .i_Data(data), .i_Clear(clr),
        .o_Locked(locked), .o_Error(err), .o_Err_Count(cnt)
    );

    lfsr_prbs_checker #(.NUM_BITS(4), .LOCK_COUNT(4), .UNLOCK_COUNT(3), .ERR_CNT_WIDTH(2)) u_sat (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Data_DV(dv), .i_Data(data), .i_Clear(clr),
        .o_Locked(locked_s), .o_Error(err_s), .o_Err_Count(cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [3:0] d, input logic c);
        @(negedge clk);
        dv   = v;
        data = d;
        clr  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_good(input logic c);
        step(1'b1, seq[idx], c);
        idx = (idx + 1) % 15;
    endtask

    task automatic send_bad(input logic c);
        step(1'b1, seq[idx] ^ 4'b0001, c);
        idx = (idx + 1) % 15;
    endtask

    initial begin
        seq = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6,
                4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8};
        rst_n = 1'b0;
        dv    = 1'b0;
        data  = 4'h0;
        clr   = 1'b0;

        // Reset held with valid words toggling: nothing may move
        for (int k = 0; k < 6; k++) step(k[0], seq[k], 1'b0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_error", 32'(err), 32'd0);
        chk("rst_count", 32'(cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 4'h0, 1'b0);
        step(1'b0, 4'h0, 1'b0);
        chk("post_rst_locked", 32'(locked), 32'd0);
        chk("post_rst_count", 32'(cnt), 32'd0);

        // Clean lock: 0000 seeds, next four matches lock
        idx = 0;
        for (int k = 0; k < 4; k++) begin
            send_good(1'b0);
            chk("lock_pending", 32'(locked), 32'd0);
        end
        send_good(1'b0);
        chk("lock_up", 32'(locked), 32'd1);
        chk("lock_count", 32'(cnt), 32'd0);
        for (int k = 0; k < 3; k++) begin
            send_good(1'b0);
            chk("clean_locked", 32'(locked), 32'd1);
            chk("clean_noerr", 32'(err), 32'd0);
        end

        // Single corrupted word while locked, then the flywheel matches again
        send_bad(1'b0);
        chk("single_err", 32'(err), 32'd1);
        chk("single_count", 32'(cnt), 32'd1);
        chk("single_locked", 32'(locked), 32'd1);
        send_good(1'b0);
        chk("single_recover_err", 32'(err), 32'd0);
        chk("single_recover_cnt", 32'(cnt), 32'd1);
        step(1'b0, 4'hF, 1'b0);
        chk("idle_noerr", 32'(err), 32'd0);
        chk("idle_locked", 32'(locked), 32'd1);

        // Three consecutive mismatches drop lock on the third
        send_bad(1'b0);
        chk("lol1_err", 32'(err), 32'd1);
        chk("lol1_locked", 32'(locked), 32'd1);
        send_bad(1'b0);
        chk("lol2_count", 32'(cnt), 32'd3);
        chk("lol2_locked", 32'(locked), 32'd1);
        send_bad(1'b0);
        chk("lol3_err", 32'(err), 32'd1);
        chk("lol3_count", 32'(cnt), 32'd4);
        chk("lol3_locked", 32'(locked), 32'd0);
        chk("lol3_sat_count", 32'(cnt_s), 32'd3);

        // Relock after 1+4 clean words
        for (int k = 0; k < 4; k++) begin
            send_good(1'b0);
            chk("relock_pending", 32'(locked), 32'd0);
            chk("relock_noerr", 32'(err), 32'd0);
        end
        send_good(1'b0);
        chk("relock_up", 32'(locked), 32'd1);
        chk("relock_count", 32'(cnt), 32'd4);

        step(1'b0, 4'h0, 1'b1);
        chk("clear_count", 32'(cnt), 32'd0);
        chk("clear_locked", 32'(locked), 32'd1);

        // Five isolated errors: wide counter reaches 5, 2-bit counter sticks at 3
        for (int k = 0; k < 5; k++) begin
            send_bad(1'b0);
            chk("iso_err", 32'(err), 32'd1);
            send_good(1'b0);
        end
        chk("iso_count", 32'(cnt), 32'd5);
        chk("iso_sat_count", 32'(cnt_s), 32'd3);
        chk("iso_locked", 32'(locked), 32'd1);

        // Clear coincident with an error: clear wins
        send_bad(1'b1);
        chk("clr_err_pulse", 32'(err), 32'd1);
        chk("clr_err_count", 32'(cnt), 32'd0);
        chk("clr_err_sat", 32'(cnt_s), 32'd0);
        send_good(1'b0);

        // Asynchronous reset while locked
        rst_n = 1'b0;
        #1;
        chk("async_rst_locked", 32'(locked), 32'd0);
        chk("async_rst_count", 32'(cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Lockup words in HUNT, then a gapped clean sequence
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 4'hF, 1'b0);
            chk("lockup_hunt", 32'(locked), 32'd0);
        end
        idx = 3;
        for (int k = 0; k < 5; k++) begin
            send_good(1'b0);
            chk("gap_locked", 32'(locked), (k == 4) ? 32'd1 : 32'd0);
            step(1'b0, 4'h0, 1'b0);
            chk("gap_noerr", 32'(err), 32'd0);
        end
        chk("gap_count", 32'(cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
